// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for mem_port_arbiter
// Purpose : FSM state encoding, requester index constants and latency limits.
// Ports   : none (package).
// Options : ARB_LOCK_EN (used by importers, not here).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int MEM_LAT_MAX = 7;
   // Wide enough to count 0..MEM_LAT_MAX-1.
   localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port bundle for mem_port_arbiter
// Purpose : groups both requester handshakes and the memory port.
// Signals : r0_*/r1_* requester req/we/addr/wdata/ack/rdata,
//           mem_we/mem_address/mem_data_out/mem_data_in memory port,
//           r0_lock/r1_lock only when ARB_LOCK_EN is defined.
// Modports: slave  - arbiter view (serves requesters, drives memory).
//           master - environment view (requesters plus memory model).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ack;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ack;
   logic [DATA_W-1:0] r1_rdata;

`ifdef ARB_LOCK_EN
   logic              r0_lock;
   logic              r1_lock;
`endif

   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_out;
   logic [DATA_W-1:0] mem_data_in;

   modport slave (
`ifdef ARB_LOCK_EN
      input  r0_lock, r1_lock,
`endif
      input  r0_req, r0_we, r0_addr, r0_wdata,
      output r0_ack, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r1_ack, r1_rdata,
      output mem_we, mem_address, mem_data_out,
      input  mem_data_in
   );

   modport master (
`ifdef ARB_LOCK_EN
      output r0_lock, r1_lock,
`endif
      output r0_req, r0_we, r0_addr, r0_wdata,
      input  r0_ack, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r1_ack, r1_rdata,
      input  mem_we, mem_address, mem_data_out,
      output mem_data_in
   );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational round-robin winner select
// Purpose : picks which requester gets the memory port this IDLE cycle.
// Ports   : req0/req1 requests, last_grant previous winner,
//           owner_valid/owner_id lock owner (ARB_LOCK_EN only),
//           valid any request pending, pick winning index.
// Options : ARB_LOCK_EN adds lock-owner priority.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
`ifdef ARB_LOCK_EN
   input  logic owner_valid,
   input  logic owner_id,
`endif
   output logic valid,
   output logic pick
);

   always_comb begin
      valid = req0 | req1;
      pick  = REQ0;
      if (req0 && req1) begin
         pick = ~last_grant;
      end else if (req1) begin
         pick = REQ1;
      end
`ifdef ARB_LOCK_EN
      // A lock owner that is still requesting overrides round-robin.
      if (owner_valid && (owner_id ? req1 : req0)) begin
         pick = owner_id;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for one memory port
// Purpose : serialises r0/r1 transactions onto a synchronous memory port.
// Ports   : clk, resetn (async active-low),
//           bus (slave modport: requester handshakes + memory port),
//           busy high outside IDLE, grant_id current/last winner.
// Options : ARB_LOCK_EN enables r0_lock/r1_lock ownership of the port.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              grant_id
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_ACCESS = ST_ACCESS;
   localparam logic [1:0] S_WAIT   = ST_WAIT;
   localparam logic [1:0] S_RESP   = ST_RESP;

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

   logic [1:0]        state;
   logic              last_grant;
   logic              winner;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   logic pick_valid;
   logic pick_id;

`ifdef ARB_LOCK_EN
   logic owner_valid;
   logic owner_id;
   logic owner_req;
   logic winner_lock;

   assign owner_req   = owner_id ? bus.r1_req  : bus.r0_req;
   assign winner_lock = winner   ? bus.r1_lock : bus.r0_lock;
`endif

   mem_arb_rr_pick u_pick (
      .req0        (bus.r0_req),
      .req1        (bus.r1_req),
      .last_grant  (last_grant),
`ifdef ARB_LOCK_EN
      .owner_valid (owner_valid),
      .owner_id    (owner_id),
`endif
      .valid       (pick_valid),
      .pick        (pick_id)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         // Starting at 1 lets requester 0 win the first tie.
         last_grant <= REQ1;
         winner     <= REQ0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         cnt        <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
`ifdef ARB_LOCK_EN
         owner_valid <= 1'b0;
         owner_id    <= REQ0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef ARB_LOCK_EN
               // Owner went idle: give up the lock; the picker already
               // ignores it this cycle because its req is low.
               if (owner_valid && !owner_req) begin
                  owner_valid <= 1'b0;
               end
`endif
               if (pick_valid) begin
                  winner    <= pick_id;
                  lat_we    <= pick_id ? bus.r1_we    : bus.r0_we;
                  lat_addr  <= pick_id ? bus.r1_addr  : bus.r0_addr;
                  lat_wdata <= pick_id ? bus.r1_wdata : bus.r0_wdata;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               cnt   <= '0;
               state <= lat_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               if (cnt == LAST_WAIT) begin
                  if (winner == REQ1) begin
                     rdata1 <= bus.mem_data_in;
                  end else begin
                     rdata0 <= bus.mem_data_in;
                  end
                  state <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
`ifdef ARB_LOCK_EN
               // Round-robin history is frozen while the port is locked.
               if (winner_lock) begin
                  owner_valid <= 1'b1;
                  owner_id    <= winner;
               end else begin
                  owner_valid <= 1'b0;
                  last_grant  <= winner;
               end
`else
               last_grant <= winner;
`endif
            end
         endcase
      end
   end

   // Memory port is decoded from state so an async reset drops it at once.
   always_comb begin
      bus.mem_we       = 1'b0;
      bus.mem_address  = '0;
      bus.mem_data_out = '0;
      if (state == S_ACCESS) begin
         bus.mem_we       = lat_we;
         bus.mem_address  = lat_addr;
         bus.mem_data_out = lat_wdata;
      end else if (state == S_WAIT) begin
         bus.mem_address  = lat_addr;
      end
   end

   assign bus.r0_ack   = (state == S_RESP) && (winner == REQ0);
   assign bus.r1_ack   = (state == S_RESP) && (winner == REQ1);
   assign bus.r0_rdata = rdata0;
   assign bus.r1_rdata = rdata1;
   assign busy         = (state != S_IDLE);
   assign grant_id     = winner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Purpose : drives two arbiter instances (MEM_LAT=1 and MEM_LAT=3).
// Options : ARB_LOCK_EN enables the lock-ownership sequence.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn1;
   logic resetn3;
   logic busy1, gid1;
   logic busy3, gid3;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk      (clk),
      .resetn   (resetn1),
      .bus      (bus1),
      .busy     (busy1),
      .grant_id (gid1)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
      .clk      (clk),
      .resetn   (resetn3),
      .bus      (bus3),
      .busy     (busy3),
      .grant_id (gid3)
   );

   // One-cycle-latency memory for u_dut1; unwritten words read as C0DE_<addr>.
   logic [31:0]  mem1 [0:255];
   logic [255:0] written = '0;
   logic [31:0]  mem1_rd;
   logic [7:0]   idx1;
   assign idx1 = bus1.mem_address[9:2];
   always @(posedge clk) begin
      if (bus1.mem_we) begin
         mem1[idx1]    <= bus1.mem_data_out;
         written[idx1] <= 1'b1;
      end
      mem1_rd <= written[idx1] ? mem1[idx1] : {16'hC0DE, bus1.mem_address[15:0]};
   end
   assign bus1.mem_data_in = mem1_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_ack, last, c0, c1;
      logic id;
      logic exp_seq [0:4];

      bus1.r0_req = 0; bus1.r0_we = 0; bus1.r0_addr = '0; bus1.r0_wdata = '0;
      bus1.r1_req = 0; bus1.r1_we = 0; bus1.r1_addr = '0; bus1.r1_wdata = '0;
      bus3.r0_req = 0; bus3.r0_we = 0; bus3.r0_addr = '0; bus3.r0_wdata = '0;
      bus3.r1_req = 0; bus3.r1_we = 0; bus3.r1_addr = '0; bus3.r1_wdata = '0;
      bus3.mem_data_in = '0;
`ifdef ARB_LOCK_EN
      bus1.r0_lock = 0; bus1.r1_lock = 0;
      bus3.r0_lock = 0; bus3.r1_lock = 0;
`endif
      resetn1 = 0;
      resetn3 = 0;
      tick();
      tick();

      // Reset state
      check("rst_busy", 32'(busy1), 0);
      check("rst_grant_id", 32'(gid1), 0);
      check("rst_r0_ack", 32'(bus1.r0_ack), 0);
      check("rst_r1_ack", 32'(bus1.r1_ack), 0);
      check("rst_mem_we", 32'(bus1.mem_we), 0);
      check("rst_mem_address", bus1.mem_address, 0);
      check("rst_mem_data_out", bus1.mem_data_out, 0);
      check("rst_r0_rdata", bus1.r0_rdata, 0);
      check("rst_r1_rdata", bus1.r1_rdata, 0);
      resetn1 = 1;
      resetn3 = 1;
      tick();

      // r0 write 0x100 <= DEADBEEF
      bus1.r0_req = 1; bus1.r0_we = 1; bus1.r0_addr = 32'h100; bus1.r0_wdata = 32'hDEADBEEF;
      tick();
      check("wr_mem_we_t1", 32'(bus1.mem_we), 1);
      check("wr_mem_address_t1", bus1.mem_address, 32'h100);
      check("wr_mem_data_out_t1", bus1.mem_data_out, 32'hDEADBEEF);
      check("wr_r0_ack_t1", 32'(bus1.r0_ack), 0);
      check("wr_grant_id", 32'(gid1), 0);
      tick();
      check("wr_mem_we_t2", 32'(bus1.mem_we), 0);
      check("wr_r0_ack_t2", 32'(bus1.r0_ack), 1);
      check("wr_r1_ack_t2", 32'(bus1.r1_ack), 0);
      bus1.r0_req = 0;
      tick();
      check("wr_r0_ack_t3", 32'(bus1.r0_ack), 0);
      check("wr_busy_t3", 32'(busy1), 0);

      // r1 read 0x100 returns the written word at t+3
      bus1.r1_req = 1; bus1.r1_we = 0; bus1.r1_addr = 32'h100;
      tick();
      check("rd_mem_address_t1", bus1.mem_address, 32'h100);
      check("rd_mem_we_t1", 32'(bus1.mem_we), 0);
      check("rd_grant_id", 32'(gid1), 1);
      tick();
      check("rd_r1_ack_t2", 32'(bus1.r1_ack), 0);
      check("rd_mem_address_t2", bus1.mem_address, 32'h100);
      tick();
      check("rd_r1_ack_t3", 32'(bus1.r1_ack), 1);
      check("rd_r1_rdata", bus1.r1_rdata, 32'hDEADBEEF);
      check("rd_r0_ack_t3", 32'(bus1.r0_ack), 0);
      check("rd_r0_rdata_untouched", bus1.r0_rdata, 0);
      bus1.r1_req = 0;
      tick();

      // Both requesters, four reads each, from reset: 0,1,0,1,... every 4 cycles
      resetn1 = 0;
      #1;
      resetn1 = 1;
      bus1.r0_we = 0; bus1.r0_addr = 32'h200;
      bus1.r1_we = 0; bus1.r1_addr = 32'h300;
      bus1.r0_req = 1; bus1.r1_req = 1;
      n_ack = 0; last = 0; c0 = 0; c1 = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (bus1.r0_ack || bus1.r1_ack) begin
            id = bus1.r1_ack;
            check("rr_order", 32'(id), 32'(n_ack % 2));
            if (n_ack == 0) check("rr_first_latency", 32'(cyc), 3);
            else            check("rr_interval", 32'(cyc - last), 4);
            if (id) check("rr_r1_rdata", bus1.r1_rdata, 32'hC0DE0300);
            else    check("rr_r0_rdata", bus1.r0_rdata, 32'hC0DE0200);
            last = cyc;
            n_ack++;
            if (id) c1++; else c0++;
            if (c0 == 4) bus1.r0_req = 0;
            if (c1 == 4) bus1.r1_req = 0;
         end
      end
      check("rr_total_acks", 32'(n_ack), 8);

      // MEM_LAT=3 read: data is only correct on the last WAIT cycle
      bus3.r0_req = 1; bus3.r0_we = 0; bus3.r0_addr = 32'h40;
      bus3.mem_data_in = 32'hBAD00000;
      for (int k = 1; k <= 5; k++) begin
         tick();
         bus3.mem_data_in = (k == 4) ? 32'h12345678 : 32'hBAD00000 + 32'(k);
         if (k <= 4) begin
            check("lat3_mem_address", bus3.mem_address, 32'h40);
            check("lat3_r0_ack_early", 32'(bus3.r0_ack), 0);
            check("lat3_mem_we", 32'(bus3.mem_we), 0);
         end else begin
            check("lat3_r0_ack", 32'(bus3.r0_ack), 1);
            check("lat3_r0_rdata", bus3.r0_rdata, 32'h12345678);
            check("lat3_mem_address_resp", bus3.mem_address, 0);
            bus3.r0_req = 0;
         end
      end
      tick();

      // Reset asserted during WAIT aborts with no ack
      bus3.r1_req = 1; bus3.r1_we = 0; bus3.r1_addr = 32'h80;
      tick();
      tick();
      check("abort_busy_before", 32'(busy3), 1);
      #2;
      resetn3 = 0;
      #1;
      check("abort_busy", 32'(busy3), 0);
      check("abort_mem_we", 32'(bus3.mem_we), 0);
      check("abort_mem_address", bus3.mem_address, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_ack", 32'(bus3.r1_ack), 0);
      end
      resetn3 = 1;
      bus3.r0_req = 1; bus3.r0_we = 0; bus3.r0_addr = 32'h44;
      tick();
      check("abort_regrant_id", 32'(gid3), 0);
      check("abort_regrant_addr", bus3.mem_address, 32'h44);
      bus3.r0_req = 0; bus3.r1_req = 0;
      for (int k = 0; k < 12; k++) tick();

`ifdef ARB_LOCK_EN
      // r1 locks the port: expect 0,1,1,1 then r0 after r1 lets go
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 1; exp_seq[3] = 1; exp_seq[4] = 0;
      resetn1 = 0;
      #1;
      resetn1 = 1;
      bus1.r0_we = 0; bus1.r0_addr = 32'h200; bus1.r0_lock = 0;
      bus1.r1_we = 0; bus1.r1_addr = 32'h300; bus1.r1_lock = 1;
      bus1.r0_req = 1; bus1.r1_req = 1;
      n_ack = 0; c1 = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (bus1.r0_ack || bus1.r1_ack) begin
            id = bus1.r1_ack;
            if (n_ack < 5) check("lock_order", 32'(id), 32'(exp_seq[n_ack]));
            n_ack++;
            if (id) c1++;
            if (c1 == 3) begin
               bus1.r1_req = 0;
               bus1.r1_lock = 0;
            end
            if (n_ack == 5) bus1.r0_req = 0;
         end
      end
      check("lock_total_acks", 32'(n_ack), 5);
`else
      exp_seq[0] = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
